// File: rtl/utm_pkg.sv
// utm_pkg
// Shared definitions for the Turing machine step controller: machine widths,
// the halt encoding, head direction codes, the sequencer state enum and a
// one-hot check used to catch corrupted machine states.
package utm_pkg;

  localparam int STATE_W = 8;
  localparam int SYM_W   = 3;

  localparam logic [STATE_W-1:0] HALT_STATE = 8'h00;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    READ   = 3'd1,
    LOOKUP = 3'd2,
    WRITE  = 3'd3,
    MOVE   = 3'd4,
    HALT   = 3'd5
  } fsm_state_t;

  // True when exactly one bit is set; clearing the lowest set bit must leave zero.
  function automatic logic is_one_hot(input logic [STATE_W-1:0] s);
    return (s != '0) && ((s & (s - STATE_W'(1))) == '0);
  endfunction

endpackage

// File: rtl/utm_head_counter.sv
// utm_head_counter
// Tape head position register. The neighbouring cell in the requested
// direction is offered combinationally as next_head, and at_edge flags a move
// that would step off either end of the tape. The owner commits a move by
// pulsing load with next_head on load_value.
//
// Ports:
//   clk, reset   clock and synchronous active-high reset (head <= START_HEAD)
//   load         load head from load_value this cycle
//   load_value   value to load
//   direction    DIR_RIGHT = toward higher addresses, DIR_LEFT = lower
//   head         current head position
//   next_head    head +/- 1 according to direction
//   at_edge      moving in direction would leave the tape
module utm_head_counter
  import utm_pkg::*;
#(
  parameter int ADDR_W     = 5,
  parameter int START_HEAD = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_value,
  input  logic              direction,
  output logic [ADDR_W-1:0] head,
  output logic [ADDR_W-1:0] next_head,
  output logic              at_edge
);

  localparam logic [ADDR_W-1:0] HEAD_START = ADDR_W'(START_HEAD);
  localparam logic [ADDR_W-1:0] HEAD_MAX   = '1;

  always_comb begin
    next_head = (direction == DIR_RIGHT) ? head + ADDR_W'(1) : head - ADDR_W'(1);
    at_edge   = ((direction == DIR_LEFT)  && (head == '0)) ||
                ((direction == DIR_RIGHT) && (head == HEAD_MAX));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head <= HEAD_START;
    end else if (load) begin
      head <= load_value;
    end
  end

endmodule

// File: rtl/utm_step_controller.sv
// utm_step_controller
// Sequencer for the Turing machine core. Each machine transition reads the
// cell under the head, gives the external lookup blocks one full cycle with
// the current one-hot state and symbol, writes the new symbol back, then moves
// the head and commits the next state. A halt lookup or an off-tape move ends
// in the terminal HALT state; only reset leaves it.
//
// Optional feature macro: UTM_STEP_COUNT_EN
//   defined   -> step_count is a saturating 16-bit count of committed steps
//   undefined -> step_count is tied to zero and has no flops
//
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   run, step               continuous-run level / single-step pulse (IDLE only)
//   tape_addr               cell address, always equal to head
//   tape_rd_req/ack/rdata   read handshake, request held until ack
//   tape_wr_req/ack/wdata   write handshake, request held until ack
//   state, sym              current one-hot state and latched symbol to lookup
//   direction, next_state,
//   next_sym                lookup results (next_state 0 = halt)
//   head                    current head position
//   busy                    sequencer is mid-step
//   halted, fault           sticky end conditions
//   step_count              committed steps
module utm_step_controller
  import utm_pkg::*;
#(
  parameter int                 ADDR_W      = 5,
  parameter int                 START_HEAD  = 16,
  parameter logic [STATE_W-1:0] RESET_STATE = 8'h01
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  input  logic               step,
  output logic [ADDR_W-1:0]  tape_addr,
  output logic               tape_rd_req,
  input  logic               tape_rd_ack,
  input  logic [SYM_W-1:0]   tape_rdata,
  output logic               tape_wr_req,
  input  logic               tape_wr_ack,
  output logic [SYM_W-1:0]   tape_wdata,
  output logic [STATE_W-1:0] state,
  output logic [SYM_W-1:0]   sym,
  input  logic               direction,
  input  logic [STATE_W-1:0] next_state,
  input  logic [SYM_W-1:0]   next_sym,
  output logic [ADDR_W-1:0]  head,
  output logic               busy,
  output logic               halted,
  output logic               fault,
  output logic [15:0]        step_count
);

  fsm_state_t         fsm;
  logic               dir_q;
  logic [STATE_W-1:0] next_state_q;
  logic [ADDR_W-1:0]  next_head;
  logic               at_edge;
  logic               commit;

  // A step commits only from MOVE when it neither halts nor falls off the tape.
  assign commit    = (fsm == MOVE) && (next_state_q != HALT_STATE) && !at_edge;
  assign tape_addr = head;

  utm_head_counter #(
    .ADDR_W     (ADDR_W),
    .START_HEAD (START_HEAD)
  ) u_head (
    .clk        (clk),
    .reset      (reset),
    .load       (commit),
    .load_value (next_head),
    .direction  (dir_q),
    .head       (head),
    .next_head  (next_head),
    .at_edge    (at_edge)
  );

  // Main sequencer. Requests and busy are registered alongside the state so
  // they line up exactly with the state they belong to.
  always_ff @(posedge clk) begin
    if (reset) begin
      fsm          <= IDLE;
      state        <= RESET_STATE;
      sym          <= '0;
      tape_rd_req  <= 1'b0;
      tape_wr_req  <= 1'b0;
      tape_wdata   <= '0;
      busy         <= 1'b0;
      halted       <= 1'b0;
      fault        <= 1'b0;
      dir_q        <= DIR_LEFT;
      next_state_q <= HALT_STATE;
    end else begin
      case (fsm)
        IDLE: begin
          if (run || step) begin
            fsm         <= READ;
            tape_rd_req <= 1'b1;
            busy        <= 1'b1;
          end
        end
        READ: begin
          if (tape_rd_ack) begin
            sym         <= tape_rdata;
            tape_rd_req <= 1'b0;
            fsm         <= LOOKUP;
          end
        end
        LOOKUP: begin
          dir_q        <= direction;
          next_state_q <= next_state;
          // A corrupted state must not touch the tape.
          if (!is_one_hot(state)) begin
            fault <= 1'b1;
            busy  <= 1'b0;
            fsm   <= HALT;
          end else begin
            tape_wdata  <= next_sym;
            tape_wr_req <= 1'b1;
            fsm         <= WRITE;
          end
        end
        WRITE: begin
          if (tape_wr_ack) begin
            tape_wr_req <= 1'b0;
            fsm         <= MOVE;
          end
        end
        MOVE: begin
          if (next_state_q == HALT_STATE) begin
            halted <= 1'b1;
            busy   <= 1'b0;
            fsm    <= HALT;
          end else if (at_edge) begin
            fault <= 1'b1;
            busy  <= 1'b0;
            fsm   <= HALT;
          end else begin
            state <= next_state_q;
            if (run) begin
              tape_rd_req <= 1'b1;
              fsm         <= READ;
            end else begin
              busy <= 1'b0;
              fsm  <= IDLE;
            end
          end
        end
        HALT: begin
        end
        default: begin
          busy <= 1'b0;
          fsm  <= IDLE;
        end
      endcase
    end
  end

`ifdef UTM_STEP_COUNT_EN
  logic [15:0] count_q;

  // Saturating count of committed steps.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else if (commit && (count_q != 16'hFFFF)) begin
      count_q <= count_q + 16'd1;
    end
  end

  assign step_count = count_q;
`else
  assign step_count = 16'h0000;
`endif

endmodule

// File: tb/tb_utm_step_controller.sv
// tb_utm_step_controller
// Directed bench for utm_step_controller. A behavioural tape answers read and
// write requests with programmable wait cycles; every accepted write is handed
// to a monitor that compares it against the expected-write queue filled when
// each step is issued. Timing, head, state and sticky flags are checked
// against hand-computed values after each scenario.
module tb_utm_step_controller;

  logic        clk;
  logic        reset;
  logic        run;
  logic        step;
  logic [4:0]  tape_addr;
  logic        tape_rd_req;
  logic        tape_rd_ack;
  logic [2:0]  tape_rdata;
  logic        tape_wr_req;
  logic        tape_wr_ack;
  logic [2:0]  tape_wdata;
  logic [7:0]  state;
  logic [2:0]  sym;
  logic        direction;
  logic [7:0]  next_state;
  logic [2:0]  next_sym;
  logic [4:0]  head;
  logic        busy;
  logic        halted;
  logic        fault;
  logic [15:0] step_count;

  int vectors;
  int miscompares;

  typedef struct {
    logic [4:0] addr;
    logic [2:0] data;
  } wr_t;

  wr_t        exp_q[$];
  logic [2:0] mem[32];
  int         rd_delay;
  int         wr_delay;
  int         rd_cnt;
  int         wr_cnt;
  logic [4:0] obs_addr;
  logic [2:0] obs_data;
  event       wr_seen;

  utm_step_controller dut (
    .clk         (clk),
    .reset       (reset),
    .run         (run),
    .step        (step),
    .tape_addr   (tape_addr),
    .tape_rd_req (tape_rd_req),
    .tape_rd_ack (tape_rd_ack),
    .tape_rdata  (tape_rdata),
    .tape_wr_req (tape_wr_req),
    .tape_wr_ack (tape_wr_ack),
    .tape_wdata  (tape_wdata),
    .state       (state),
    .sym         (sym),
    .direction   (direction),
    .next_state  (next_state),
    .next_sym    (next_sym),
    .head        (head),
    .busy        (busy),
    .halted      (halted),
    .fault       (fault),
    .step_count  (step_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected committed-step count depends on whether the counter is built in.
  function automatic logic [31:0] expCount(input int n);
`ifdef UTM_STEP_COUNT_EN
    return 32'(n);
`else
    return 32'(0 * n);
`endif
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic timeoutFail(input string name);
    vectors++;
    miscompares++;
    $display("[TB] FAIL %s: wait bound expired", name);
  endtask

  // Behavioural tape, updated away from the active edge. Acks are given on
  // the falling edge so the DUT samples them at the next rising edge.
  always @(negedge clk) begin
    if (tape_rd_req) begin
      if (rd_cnt >= rd_delay) begin
        tape_rd_ack = 1'b1;
        tape_rdata  = mem[tape_addr];
        rd_cnt      = 0;
      end else begin
        tape_rd_ack = 1'b0;
        rd_cnt++;
      end
    end else begin
      tape_rd_ack = 1'b0;
      rd_cnt      = 0;
    end
    if (tape_wr_req) begin
      if (wr_cnt >= wr_delay) begin
        tape_wr_ack     = 1'b1;
        mem[tape_addr]  = tape_wdata;
        obs_addr        = tape_addr;
        obs_data        = tape_wdata;
        wr_cnt          = 0;
        -> wr_seen;
      end else begin
        tape_wr_ack = 1'b0;
        wr_cnt++;
      end
    end else begin
      tape_wr_ack = 1'b0;
      wr_cnt      = 0;
    end
  end

  // Scoreboard monitor: every write the tape accepts must match the head of
  // the expected queue.
  always @(wr_seen) begin
    if (exp_q.size() == 0) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL unexpected_write: got addr %0d data %0b, expected none",
               obs_addr, obs_data);
    end else begin
      wr_t e;
      e = exp_q.pop_front();
      checkOutput("write_addr", 32'(obs_addr), 32'(e.addr));
      checkOutput("write_data", 32'(obs_data), 32'(e.data));
    end
  end

  task automatic applyStimulus(input logic dir, input logic [7:0] ns, input logic [2:0] nsym);
    direction  = dir;
    next_state = ns;
    next_sym   = nsym;
  endtask

  task automatic pushExpect(input logic [4:0] addr, input logic [2:0] data);
    wr_t e;
    e.addr = addr;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b1;
    run   = 1'b0;
    step  = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic pulseStep();
    @(negedge clk);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
  endtask

  // Counts busy cycles from the current falling edge; optionally drops run
  // at a given cycle and tracks read-request length and address stability.
  task automatic runUntilIdle(input int limit, input int drop_run_at, output int cycles,
                              output int rd_cycles, output int addr_moves);
    logic       prev_rd;
    logic [4:0] prev_addr;
    cycles     = 0;
    rd_cycles  = 0;
    addr_moves = 0;
    prev_rd    = 1'b0;
    prev_addr  = tape_addr;
    while (busy && cycles < limit) begin
      cycles++;
      if (tape_rd_req) begin
        rd_cycles++;
        if (prev_rd && tape_addr != prev_addr) addr_moves++;
      end
      prev_rd   = tape_rd_req;
      prev_addr = tape_addr;
      if (cycles == drop_run_at) run = 1'b0;
      @(negedge clk);
    end
    if (cycles >= limit) timeoutFail("busy_timeout");
  endtask

  initial begin
    int cyc;
    int rdc;
    int mv;
    int seen;
    vectors     = 0;
    miscompares = 0;
    rd_delay    = 0;
    wr_delay    = 0;
    rd_cnt      = 0;
    wr_cnt      = 0;
    tape_rd_ack = 1'b0;
    tape_wr_ack = 1'b0;
    tape_rdata  = 3'b000;
    reset       = 1'b1;
    run         = 1'b0;
    step        = 1'b0;
    for (int i = 0; i < 32; i++) mem[i] = 3'b000;
    applyStimulus(1'b1, 8'h02, 3'b000);

    // Reset state
    doReset();
    checkOutput("rst_head", 32'(head), 32'd16);
    checkOutput("rst_addr", 32'(tape_addr), 32'd16);
    checkOutput("rst_state", 32'(state), 32'h01);
    checkOutput("rst_flags", {27'd0, busy, halted, fault, tape_rd_req, tape_wr_req}, 32'd0);
    checkOutput("rst_sym_wdata", {26'd0, sym, tape_wdata}, 32'd0);
    checkOutput("rst_count", 32'(step_count), 32'd0);

    // Single step
    $display("[TB] single step");
    mem[16] = 3'b001;
    applyStimulus(1'b1, 8'h02, 3'b100);
    pushExpect(5'd16, 3'b100);
    pulseStep();
    runUntilIdle(50, 0, cyc, rdc, mv);
    checkOutput("step_cycles", 32'(cyc), 32'd4);
    checkOutput("step_head", 32'(head), 32'd17);
    checkOutput("step_state", 32'(state), 32'h02);
    checkOutput("step_sym", 32'(sym), 32'b001);
    checkOutput("step_count", 32'(step_count), expCount(1));
    checkOutput("step_cell16", 32'(mem[16]), 32'b100);

    // Continuous run, three steps back-to-back
    $display("[TB] run three steps");
    doReset();
    applyStimulus(1'b1, 8'h02, 3'b010);
    pushExpect(5'd16, 3'b010);
    pushExpect(5'd17, 3'b010);
    pushExpect(5'd18, 3'b010);
    @(negedge clk);
    run = 1'b1;
    @(negedge clk);
    runUntilIdle(100, 10, cyc, rdc, mv);
    checkOutput("run_cycles", 32'(cyc), 32'd12);
    checkOutput("run_head", 32'(head), 32'd19);
    checkOutput("run_count", 32'(step_count), expCount(3));

    // Delayed read acknowledge
    $display("[TB] delayed read");
    doReset();
    mem[16]  = 3'b111;
    rd_delay = 3;
    applyStimulus(1'b1, 8'h04, 3'b011);
    pushExpect(5'd16, 3'b011);
    pulseStep();
    runUntilIdle(50, 0, cyc, rdc, mv);
    rd_delay = 0;
    checkOutput("rdwait_cycles", 32'(cyc), 32'd7);
    checkOutput("rdwait_req_len", 32'(rdc), 32'd4);
    checkOutput("rdwait_addr_moves", 32'(mv), 32'd0);
    checkOutput("rdwait_sym", 32'(sym), 32'b111);
    checkOutput("rdwait_state", 32'(state), 32'h04);

    // Halt transition
    $display("[TB] halt");
    doReset();
    applyStimulus(1'b1, 8'h00, 3'b101);
    pushExpect(5'd16, 3'b101);
    pulseStep();
    runUntilIdle(50, 0, cyc, rdc, mv);
    checkOutput("halt_cycles", 32'(cyc), 32'd4);
    checkOutput("halt_flags", {30'd0, halted, fault}, 32'b10);
    checkOutput("halt_head", 32'(head), 32'd16);
    checkOutput("halt_state", 32'(state), 32'h01);
    checkOutput("halt_count", 32'(step_count), expCount(0));
    step = 1'b1;
    run  = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      step = 1'b0;
      if (busy || tape_rd_req || tape_wr_req) seen++;
    end
    run = 1'b0;
    checkOutput("halt_ignores_ctrl", 32'(seen), 32'd0);
    checkOutput("halt_sticky", 32'(halted), 32'd1);

    // Walk left to cell 0, then try to move off the tape
    $display("[TB] left edge fault");
    doReset();
    applyStimulus(1'b0, 8'h02, 3'b011);
    for (int a = 16; a >= 0; a--) pushExpect(5'(a), 3'b011);
    @(negedge clk);
    run = 1'b1;
    @(negedge clk);
    runUntilIdle(200, 0, cyc, rdc, mv);
    run = 1'b0;
    checkOutput("edge_cycles", 32'(cyc), 32'd68);
    checkOutput("edge_flags", {30'd0, halted, fault}, 32'b01);
    checkOutput("edge_head", 32'(head), 32'd0);
    checkOutput("edge_state", 32'(state), 32'h02);
    checkOutput("edge_count", 32'(step_count), expCount(16));

    // A non-one-hot state faults in LOOKUP without writing
    $display("[TB] corrupt state");
    doReset();
    applyStimulus(1'b1, 8'h03, 3'b110);
    pushExpect(5'd16, 3'b110);
    pulseStep();
    runUntilIdle(50, 0, cyc, rdc, mv);
    checkOutput("bad_state_committed", 32'(state), 32'h03);
    checkOutput("bad_ok_fault", 32'(fault), 32'd0);
    applyStimulus(1'b1, 8'h02, 3'b001);
    pulseStep();
    runUntilIdle(50, 0, cyc, rdc, mv);
    checkOutput("bad_cycles", 32'(cyc), 32'd2);
    checkOutput("bad_fault", 32'(fault), 32'd1);
    checkOutput("bad_head", 32'(head), 32'd17);
    checkOutput("bad_cell17", 32'(mem[17]), 32'b010);

    // Reset while a write is outstanding
    $display("[TB] reset during write");
    doReset();
    applyStimulus(1'b1, 8'h02, 3'b100);
    pushExpect(5'd16, 3'b100);
    pulseStep();
    runUntilIdle(50, 0, cyc, rdc, mv);
    checkOutput("pre_head", 32'(head), 32'd17);
    wr_delay = 100;
    pulseStep();
    cyc = 0;
    while (!tape_wr_req && cyc < 20) begin
      cyc++;
      @(negedge clk);
    end
    if (cyc >= 20) timeoutFail("wr_req_timeout");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("rstw_wr_req", 32'(tape_wr_req), 32'd0);
    checkOutput("rstw_head", 32'(head), 32'd16);
    checkOutput("rstw_state", 32'(state), 32'h01);
    checkOutput("rstw_count", 32'(step_count), 32'd0);
    checkOutput("rstw_busy", 32'(busy), 32'd0);
    reset    = 1'b0;
    wr_delay = 0;

    repeat (3) @(negedge clk);
    checkOutput("scoreboard_drain", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1, "[TB] timeout");
  end

endmodule
